// File: rtl/stream_demux_1ton.sv
// stream_demux_1ton: registered 1-to-NCH stream demultiplexer.
// Each beat is routed by in_sel (MODE 0) or by a round-robin pointer (MODE 1).
// Every output channel has a one-entry holding register with a valid/ready
// handshake. A drain and a refill in the same cycle sustain one beat per cycle.
// In MODE 0, a select >= NCH consumes the beat, drops it, and pulses sel_err.
// Optional build macro STREAM_DEMUX_STATS_EN adds the stat_clr input and the
// stat_cnt output, which holds one 16-bit saturating handshake counter per channel.
module stream_demux_1ton #(
    parameter int WIDTH = 8,
    parameter int NCH   = 4,
    parameter int SELW  = 2,
    parameter int MODE  = 0
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [WIDTH-1:0]       in_data,
    input  logic [SELW-1:0]        in_sel,
    output logic [NCH-1:0]         out_valid,
    input  logic [NCH-1:0]         out_ready,
    output logic [NCH*WIDTH-1:0]   out_data,
    output logic                   sel_err
`ifdef STREAM_DEMUX_STATS_EN
    ,
    input  logic                   stat_clr,
    output logic [NCH*16-1:0]      stat_cnt
`endif
);

    logic [NCH-1:0]       valid_q, valid_d;
    logic [NCH*WIDTH-1:0] data_q, data_d;
    logic                 sel_err_q, sel_err_d;
    logic [SELW-1:0]      rr_ptr_q, rr_ptr_d;

    logic [SELW-1:0]      tgt_s;
    logic                 sel_ok_s;
    logic                 tgt_full_s;
    logic                 tgt_rdy_s;
    logic                 accept_s;

    // Resolve the target channel and its occupancy; in_ready never looks at in_valid
    always_comb begin
        if (MODE == 1) begin
            tgt_s = rr_ptr_q;
        end else begin
            tgt_s = in_sel;
        end
        sel_ok_s   = 1'b0;
        tgt_full_s = 1'b0;
        tgt_rdy_s  = 1'b0;
        for (int k = 0; k < NCH; k++) begin
            sel_ok_s   = sel_ok_s   | (tgt_s == SELW'(k));
            tgt_full_s = tgt_full_s | ((tgt_s == SELW'(k)) & valid_q[k]);
            tgt_rdy_s  = tgt_rdy_s  | ((tgt_s == SELW'(k)) & out_ready[k]);
        end
        // Out-of-range selects are always accepted so they can be dropped
        in_ready = ~sel_ok_s | ~tgt_full_s | tgt_rdy_s;
        accept_s = in_valid & in_ready;
    end

    // Next state of the channel holding registers, error pulse and round-robin pointer
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < NCH; k++) begin
            if (accept_s && sel_ok_s && (tgt_s == SELW'(k))) begin
                valid_d[k]                = 1'b1;
                data_d[k*WIDTH +: WIDTH]  = in_data;
            end else if (valid_q[k] && out_ready[k]) begin
                valid_d[k] = 1'b0;
            end else begin
                valid_d[k] = valid_q[k];
            end
        end

        sel_err_d = accept_s & ~sel_ok_s;

        if ((MODE == 1) && accept_s) begin
            if (rr_ptr_q == SELW'(NCH - 1)) begin
                rr_ptr_d = {SELW{1'b0}};
            end else begin
                rr_ptr_d = rr_ptr_q + SELW'(1);
            end
        end else begin
            rr_ptr_d = rr_ptr_q;
        end
    end

    // State registers; reset discards any held beats
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= {NCH{1'b0}};
            data_q    <= {(NCH*WIDTH){1'b0}};
            sel_err_q <= 1'b0;
            rr_ptr_q  <= {SELW{1'b0}};
        end else begin
            valid_q   <= valid_d;
            data_q    <= data_d;
            sel_err_q <= sel_err_d;
            rr_ptr_q  <= rr_ptr_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;
    assign sel_err   = sel_err_q;

`ifdef STREAM_DEMUX_STATS_EN
    logic [NCH*16-1:0] stat_q, stat_d;

    // Per-channel saturating handshake counters; clear wins over increment
    always_comb begin
        stat_d = stat_q;
        for (int k = 0; k < NCH; k++) begin
            if (stat_clr) begin
                stat_d[k*16 +: 16] = 16'h0000;
            end else if (valid_q[k] && out_ready[k] && (stat_q[k*16 +: 16] != 16'hFFFF)) begin
                stat_d[k*16 +: 16] = stat_q[k*16 +: 16] + 16'h0001;
            end else begin
                stat_d[k*16 +: 16] = stat_q[k*16 +: 16];
            end
        end
    end

    // Counter registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= {(NCH*16){1'b0}};
        end else begin
            stat_q <= stat_d;
        end
    end

    assign stat_cnt = stat_q;
`endif

endmodule
